// File: rtl/deep_pkg.sv
// deep_pkg: shared widths, image types and loader state encoding
package deep_pkg;
    localparam int NUM_PIXELS  = 784;
    localparam int NUM_OUTPUTS = 10;
    localparam int WORD_W      = 32;
    localparam int PIX_SHIFT   = 9;
    localparam int PIX_CNT_W   = $clog2(NUM_PIXELS);
    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [NUM_PIXELS-1:0] image_t;
    typedef enum logic [1:0] {S_LABEL, S_PIX, S_START, S_WAIT} ld_state_t;
endpackage

// File: rtl/pixel_fmt.sv
// pixel_fmt: zero-extends a pixel byte and shifts it into network fixed point
module pixel_fmt
    import deep_pkg::*;
#(
    parameter int SHIFT = PIX_SHIFT
) (
    input  logic [7:0] i_byte,
    output word_t      o_word
);
    assign o_word = word_t'(i_byte) << SHIFT;
endmodule

// File: rtl/image_loader.sv
// image_loader: assembles a label plus NUM_PIXELS pixel bytes and hands the frame to the network
module image_loader
    import deep_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_rx_ready,
    input  logic             i_flush,
    input  logic             i_net_done,
    output image_t           o_image_out,
    output logic [7:0]       o_label_out,
    output logic             o_start,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_frames_done
);
    localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(NUM_PIXELS - 1);
    ld_state_t            r_state;
    logic [PIX_CNT_W-1:0] r_pix_cnt;
    image_t               r_image;
    logic [7:0]           r_label;
    logic                 r_start;
    logic                 r_busy;
    logic                 r_rx_ready;
    logic [CNT_W-1:0]     r_frames;
    word_t                w_pix_word;
    logic                 w_xfer;
    pixel_fmt #(.SHIFT(PIX_SHIFT)) u_fmt (
        .i_byte (i_rx_data),
        .o_word (w_pix_word)
    );
    assign w_xfer = i_rx_valid && r_rx_ready;
    // rx_ready, start and busy are registered alongside the state they decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_LABEL;
            r_pix_cnt  <= '0;
            r_image    <= '0;
            r_label    <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_rx_ready <= 1'b1;
            r_frames   <= '0;
        end else if (i_flush) begin
            r_state    <= S_LABEL;
            r_pix_cnt  <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_rx_ready <= 1'b1;
        end else begin
            case (r_state)
                S_LABEL: if (w_xfer) begin
                    r_label   <= i_rx_data;
                    r_pix_cnt <= '0;
                    r_state   <= S_PIX;
                end
                S_PIX: if (w_xfer) begin
                    r_image[r_pix_cnt] <= w_pix_word;
                    if (r_pix_cnt == LAST_PIX) begin
                        r_state    <= S_START;
                        r_start    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_rx_ready <= 1'b0;
                    end else begin
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                    r_start <= 1'b0;
                end
                S_WAIT: if (i_net_done) begin
                    r_frames   <= r_frames + 1'b1;
                    r_state    <= S_LABEL;
                    r_busy     <= 1'b0;
                    r_rx_ready <= 1'b1;
                end
                default: r_state <= S_LABEL;
            endcase
        end
    end
    assign o_rx_ready    = r_rx_ready;
    assign o_image_out   = r_image;
    assign o_label_out   = r_label;
    assign o_start       = r_start;
    assign o_busy        = r_busy;
    assign o_frames_done = r_frames;
endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Upstream feeder for the forward-pass network top.
- Receives a framed byte stream from the host link: one label byte, then NUM_PIXELS pixel bytes.
- Converts each pixel to 32-bit fixed point and assembles the full image vector.
- Pulses start to the network, then holds image and label stable until the network reports done.

Parameters:
NUM_PIXELS, 784, pixels per frame; image_out has NUM_PIXELS words
PIX_SHIFT, 9, left shift applied to each pixel byte (fractional bits of network fixed point)
CNT_W, 16, width of frames_done counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rx_data  input  8  stream byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte
flush  input  1  abort the current frame and resynchronise to the label byte
net_done  input  1  network finished the current frame (level or pulse)
image_out  output  NUM_PIXELS x 32  packed image, word i = pixel i
label_out  output  8  label of the current frame
start  output  1  one-cycle start pulse to the network
busy  output  1  a frame is in flight (S_START or S_WAIT)
frames_done  output  CNT_W  count of completed frames, wraps

Behaviour:
- Transfer occurs on any cycle with rx_valid && rx_ready. No transfer means no state change.
- State S_LABEL:
  - rx_ready=1.
  - On transfer: label_out<=rx_data, pix_cnt<=0, go to S_PIX.
- State S_PIX:
  - rx_ready=1.
  - On transfer: image_out[pix_cnt] <= zero-extended rx_data << PIX_SHIFT, giving range 0..255*512, upper bits 0.
  - pix_cnt increments on each transfer.
  - On the transfer with pix_cnt==NUM_PIXELS-1, go to S_START.
- State S_START:
  - rx_ready=0, start=1 for exactly this one cycle.
  - Next state S_WAIT unconditionally.
- State S_WAIT:
  - rx_ready=0, start=0.
  - On net_done=1: frames_done increments (mod 2^CNT_W), go to S_LABEL.
  - net_done is not sampled in S_START, so a stale done level cannot complete a frame early.
- busy=1 in S_START and S_WAIT, else 0.
- net_done in S_LABEL or S_PIX is ignored.
- Latency:
  - The last pixel transfer at cycle N gives start=1 at N+1.
  - rx_ready rises the cycle after net_done is sampled in S_WAIT.
- image_out and label_out are registered. They change only on their own transfers and hold through S_START and S_WAIT.
- Pixels not overwritten keep prior-frame values; every full frame overwrites all NUM_PIXELS words.
- flush:
  - Highest priority after rst.
  - Next state S_LABEL, pix_cnt<=0.
  - A byte presented in the same cycle is dropped. rx_ready is still driven by the current state, so the host sees the byte accepted but it is discarded.
  - image_out, label_out and frames_done are retained.
  - Asserted in S_WAIT, flush abandons the frame without incrementing frames_done; the network is not notified.
- rst:
  - state=S_LABEL, pix_cnt=0, all image_out words 0, label_out=0, start=0, busy=0, frames_done=0.
  - rx_ready=1 from the first cycle after reset.
  - Reset mid-frame discards partial data identically.
- pix_cnt is never allowed past NUM_PIXELS-1; there is no wrap within a frame.

Decomposition:
- Shared package (deep_pkg):
  - NUM_PIXELS, NUM_OUTPUTS (10), WORD_W (32), PIX_SHIFT.
  - typedef word_t (logic [31:0]).
  - typedef image_t (word_t [NUM_PIXELS-1:0]).
  - loader state enum {S_LABEL, S_PIX, S_START, S_WAIT}.
- One natural sub-module, pixel_fmt: combinational byte to word_t conversion, shift and zero-extend. It is reused later by the training-data path.
- The FSM, counter and image register array stay in image_loader.

Test Plan:
1. Reset then a full frame: label 0x07, pixels i mod 256 for i=0..783 -> label_out=7, image_out[3]=0x600, image_out[783]=0x0F*512=0x1E00, start high exactly one cycle after the 785th transfer, busy=1, rx_ready=0.
2. Backpressure/holdoff: rx_valid kept high during S_WAIT with data 0xFF -> no transfer, image_out unchanged. net_done pulse -> frames_done=1, rx_ready=1 next cycle, next byte taken as label.
3. Gapped stream: random rx_valid duty (~30%) over a frame of all-0xFF pixels -> every word = 0x0001FE00, exactly one start pulse.
4. flush at pixel 400 coinciding with a valid byte -> byte dropped, state S_LABEL. Next frame with label 0x02 completes normally; frames_done unchanged by the aborted frame.
5. net_done held high continuously across frames -> no extra frames_done increments in S_LABEL/S_PIX; exactly one increment per frame, taken in S_WAIT.
6. rst asserted in S_WAIT and in mid-S_PIX -> all outputs return to reset values next cycle, no start pulse, frames_done=0.
